vector_sequencer: RTL
=====================

Name: vector_sequencer

Overview:
- Synthesisable successor to the memory-driven model stimulus loop.
- Walks a combinational-read vector memory from a base address and issues each IN_DIM-channel vector to the model under valid/ready.
- Captures the model's OUT_DIM-channel result and presents it on a downstream valid/ready result port.
- Stops on an all-ones sentinel in channel 0, or when the vector limit is reached.

Parameters:
- DATA_W, 16, width of one channel.
- IN_DIM, 4, input channels per vector.
- OUT_DIM, 2, output channels per result.
- ADDR_W, 32, memory address width.
- BASE_ADDR, 0, first address fetched after start.
- MAX_VEC, 1024, maximum vectors per run; 0 means unlimited.
- CNT_W, 16, width of vec_count.
- TIMEOUT_CYC, 1024, watchdog limit; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- mem_addr  out  ADDR_W  address to the vector memory.
- mem_data  in  IN_DIM*DATA_W  combinational memory read data; channel k at bits [k*DATA_W +: DATA_W].
- dut_in_data  out  IN_DIM*DATA_W  registered vector to the model.
- dut_in_valid  out  1  vector valid.
- dut_in_ready  in  1  model accepts the vector.
- dut_out_data  in  OUT_DIM*DATA_W  model result.
- dut_out_valid  in  1  model result valid.
- dut_out_ready  out  1  sequencer accepts the result.
- res_data  out  OUT_DIM*DATA_W  captured result.
- res_valid  out  1  result available downstream.
- res_ready  in  1  downstream accepts the result.
- vec_count  out  CNT_W  vectors completed in the current run.
- busy  out  1  high in FETCH, ISSUE, WAIT_OUT and EMIT.
- done  out  1  high in DONE.
- timeout  out  1  watchdog fired; see Optional Feature.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - mem_addr = BASE_ADDR.
  - dut_in_data, res_data, vec_count = 0.
  - dut_in_valid, dut_out_ready, res_valid, busy, done, timeout = 0.
- States:
  - IDLE: start -> FETCH; mem_addr = BASE_ADDR, vec_count = 0.
  - FETCH (one cycle): register mem_data into dut_in_data. If channel 0 of mem_data equals {DATA_W{1'b1}}, or (MAX_VEC != 0 and vec_count == MAX_VEC) -> DONE. Otherwise -> ISSUE.
  - ISSUE: dut_in_valid = 1; dut_in_data held stable. dut_in_ready -> WAIT_OUT.
  - WAIT_OUT: dut_out_ready = 1. dut_out_valid -> capture dut_out_data into res_data -> EMIT.
  - EMIT: res_valid = 1; res_data held stable. res_ready -> vec_count += 1, mem_addr += 1 -> FETCH.
  - DONE: done = 1. start -> FETCH with mem_addr = BASE_ADDR, vec_count = 0, timeout cleared.
- Timing:
  - Minimum per-vector period is 4 cycles, reached when all handshakes are high on first offer.
  - First dut_in_valid is asserted 2 cycles after the start cycle.
- Handshake rules:
  - A transfer occurs when valid and ready are both high at posedge.
  - Outputs never deassert valid or change data before the transfer completes.
- Boundary conditions:
  - dut_out_valid outside WAIT_OUT is ignored; dut_out_ready is low there.
  - start while busy is ignored.
  - mem_addr wraps modulo 2^ADDR_W.
  - vec_count never exceeds MAX_VEC. When MAX_VEC = 0 it wraps modulo 2^CNT_W.
  - A sentinel vector is never issued and never counted.
  - Reset mid-run aborts immediately to reset values; no partial result is emitted.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_OUT and increments each WAIT_OUT cycle without dut_out_valid.
  - When it reaches TIMEOUT_CYC -> DONE with timeout = 1; vec_count is unchanged.
  - timeout holds until reset or the next accepted start.
- Undefined: WAIT_OUT waits indefinitely; timeout is tied 0 and no counter is synthesised.

Test Plan:
- Single vector: memory holds 0x0001..0x0004 at addr 0 and all-F at addr 1; model echoes channels 0..1; all readies high. Expect res_data = {0x0002,0x0001}, vec_count = 1, done in cycle 6 after start, dut_in_valid asserted exactly once.
- Immediate sentinel: channel 0 at BASE_ADDR = 0xFFFF. Expect DONE 2 cycles after start, vec_count = 0, dut_in_valid never high.
- Backpressure: dut_in_ready low for 3 cycles and res_ready low for 5 cycles. Expect dut_in_data and res_data stable throughout, 1 result, no duplicate count.
- Limit: MAX_VEC = 3, 10 valid vectors. Expect exactly 3 results, vec_count = 3, mem_addr = BASE_ADDR+3 at DONE.
- Mid-run reset: assert reset during EMIT of vector 2. Expect all outputs at reset values within the same cycle; after release, start reruns from BASE_ADDR with vec_count = 0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYC = 8: model never asserts dut_out_valid. Expect DONE with timeout = 1 after 8 WAIT_OUT cycles; a new start clears timeout.

Source files
------------

// File: rtl/vector_sequencer.sv
// vector_sequencer: walks a combinational-read vector memory from BASE_ADDR,
// issues each IN_DIM-channel vector to a model over valid/ready, captures the
// OUT_DIM-channel result and re-offers it downstream over valid/ready.
// A run ends on an all-ones channel 0 (sentinel) or after MAX_VEC vectors
// (MAX_VEC = 0 means unlimited).
// Optional build macro SEQ_TIMEOUT_EN adds a WAIT_OUT watchdog that ends the
// run with timeout = 1 after TIMEOUT_CYC cycles without a model result.
module vector_sequencer #(
    parameter int unsigned        DATA_W      = 16,
    parameter int unsigned        IN_DIM      = 4,
    parameter int unsigned        OUT_DIM     = 2,
    parameter int unsigned        ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        MAX_VEC     = 1024,
    parameter int unsigned        CNT_W       = 16,
    parameter int unsigned        TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [IN_DIM*DATA_W-1:0]    mem_data,
    output logic [IN_DIM*DATA_W-1:0]    dut_in_data,
    output logic                        dut_in_valid,
    input  logic                        dut_in_ready,
    input  logic [OUT_DIM*DATA_W-1:0]   dut_out_data,
    input  logic                        dut_out_valid,
    output logic                        dut_out_ready,
    output logic [OUT_DIM*DATA_W-1:0]   res_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [CNT_W-1:0]            vec_count,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_OUT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [DATA_W-1:0] SENTINEL = '1;
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(MAX_VEC);
    localparam bit                LIMIT_EN = (MAX_VEC != 0);

    state_t state;
    logic   is_sentinel;
    logic   at_limit;

    assign is_sentinel = (mem_data[DATA_W-1:0] == SENTINEL);
    assign at_limit    = LIMIT_EN && (vec_count == LIMIT);

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_fire;

    // Fires on the TIMEOUT_CYC-th consecutive WAIT_OUT cycle with no result.
    assign wd_fire = !dut_out_valid && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // Sequencer FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            mem_addr      <= BASE_ADDR;
            dut_in_data   <= '0;
            dut_in_valid  <= 1'b0;
            dut_out_ready <= 1'b0;
            res_data      <= '0;
            res_valid     <= 1'b0;
            vec_count     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt        <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        mem_addr  <= BASE_ADDR;
                        vec_count <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        timeout   <= 1'b0;
`endif
                    end
                end

                S_FETCH: begin
                    dut_in_data <= mem_data;
                    if (is_sentinel || at_limit) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state        <= S_ISSUE;
                        dut_in_valid <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    if (dut_in_ready) begin
                        state         <= S_WAIT_OUT;
                        dut_in_valid  <= 1'b0;
                        dut_out_ready <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        wd_cnt        <= '0;
`endif
                    end
                end

                S_WAIT_OUT: begin
                    if (dut_out_valid) begin
                        state         <= S_EMIT;
                        res_data      <= dut_out_data;
                        dut_out_ready <= 1'b0;
                        res_valid     <= 1'b1;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wd_fire) begin
                        state         <= S_DONE;
                        dut_out_ready <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        timeout       <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end

                S_EMIT: begin
                    if (res_ready) begin
                        state     <= S_FETCH;
                        res_valid <= 1'b0;
                        vec_count <= vec_count + CNT_W'(1);
                        mem_addr  <= mem_addr + ADDR_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
